dm_sram_responder: RTL

- Memory-side responder for the core's data-memory port. It accepts the load/store unit's request: active-low write enable, 32-bit active-low bit-write mask, byte address, and lane-placed store data.
- Holds a word-organised data array, applies bit-masked writes, and returns load data right-aligned by byte offset, ready for the LSU's sign/zero extension.
- A wait-state FSM models slow memory and stalls the pipeline while an access is in flight.

---
 rtl/dm_sram_responder.sv | 131 +++++++++++++
 1 files changed

// File: rtl/dm_sram_responder.sv
// Data-memory responder: word array with bit-masked writes, right-aligned reads and a wait-state FSM.
// Define DM_ERR_EN to flag (and neutralise) accesses whose address lies above the array.
module dm_sram_responder #(
  parameter int DEPTH    = 16384,
  parameter int WAIT_CYC = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        web,
  input  logic [31:0] bweb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        stall,
  output logic        err
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        cap_web;
  logic [31:0] cap_bweb;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic        err_q;

  logic [31:0] mem [DEPTH];

  logic          acc_go;
  logic          acc_web;
  logic          acc_oor;
  logic [31:0]   acc_bweb;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [AW-1:0] acc_idx;
  logic [31:0]   acc_word;

  // With no wait states the access happens on the accepting edge, so it uses the live request.
  always_comb begin
    acc_go    = 1'b0;
    acc_web   = cap_web;
    acc_bweb  = cap_bweb;
    acc_addr  = cap_addr;
    acc_wdata = cap_wdata;
    if (state == IDLE) begin
      acc_web   = web;
      acc_bweb  = bweb;
      acc_addr  = addr;
      acc_wdata = wdata;
      acc_go    = req && (WAIT_CYC == 0);
    end else begin
      acc_go = (state == WAIT) && (cnt == 4'd1);
    end
    if (rst) begin
      acc_go = 1'b0;
    end
  end

  assign acc_idx  = acc_addr[AW+1:2];
  assign acc_word = mem[acc_idx];

`ifdef DM_ERR_EN
  assign acc_oor = |acc_addr[31:AW+2];
`else
  logic unused_hi;
  assign unused_hi = ^acc_addr[31:AW+2];
  assign acc_oor   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (acc_go && !acc_web && !acc_oor) begin
      mem[acc_idx] <= (acc_word & acc_bweb) | (acc_wdata & ~acc_bweb);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rdata     <= 32'd0;
      ack       <= 1'b0;
      err_q     <= 1'b0;
      cap_web   <= 1'b1;
      cap_bweb  <= '1;
      cap_addr  <= 32'd0;
      cap_wdata <= 32'd0;
    end else begin
      ack   <= 1'b0;
      err_q <= 1'b0;
      if (acc_go && acc_web) begin
        rdata <= acc_oor ? 32'd0 : (acc_word >> {acc_addr[1:0], 3'b000});
      end
      case (state)
        IDLE: begin
          if (req) begin
            cap_web   <= web;
            cap_bweb  <= bweb;
            cap_addr  <= addr;
            cap_wdata <= wdata;
            if (WAIT_CYC == 0) begin
              state <= DONE;
              ack   <= 1'b1;
              err_q <= acc_oor;
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_CYC);
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= DONE;
            ack   <= 1'b1;
            err_q <= acc_oor;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign stall = req && (state != DONE);
  assign err   = err_q;

endmodule
